// File: rtl/icache_line_pkg.sv
// Shared definitions for the multi-word-line direct-mapped instruction cache.
// Default geometry and refill FSM encoding.
package icache_line_pkg;

  localparam int unsigned ICL_ADDR_WIDTH    = 18;
  localparam int unsigned ICL_INDEX_BITS    = 6;
  localparam int unsigned ICL_WORD_OFF_BITS = 2;

  typedef enum logic [1:0] {
    IcIdle   = 2'd0,
    IcRefill = 2'd1,
    IcDrain  = 2'd2
  } ic_state_e;

endpackage

// File: rtl/icache_line_data.sv
// Instruction word storage: one synchronous write port (refill),
// one asynchronous read port (lookup). Contents are not reset.
module icache_line_data
  import icache_line_pkg::*;
#(
  parameter int unsigned ADDR_BITS = ICL_INDEX_BITS + ICL_WORD_OFF_BITS
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [31:0]          wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [31:0]          rdata
);

  localparam int unsigned Depth = 2 ** ADDR_BITS;

  logic [31:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/icache_line.sv
// Direct-mapped instruction cache with multi-word lines, burst refill,
// rollback abort (with drain of the outstanding word) and fence.i flush.
module icache_line
  import icache_line_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = ICL_ADDR_WIDTH,
  parameter int unsigned INDEX_BITS    = ICL_INDEX_BITS,
  parameter int unsigned WORD_OFF_BITS = ICL_WORD_OFF_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rollback,
  input  logic        flush,
  input  logic [31:0] IF_addr,
  input  logic        IF_addr_sgn,
  output logic [31:0] IF_val,
  output logic        IF_val_sgn,
  output logic [31:0] Mc_addr,
  output logic        Mc_addr_sgn,
  input  logic [31:0] MC_val,
  input  logic        MC_val_sgn
);

  localparam int unsigned LineBits = ADDR_WIDTH - 2 - WORD_OFF_BITS;
  localparam int unsigned TagBits  = LineBits - INDEX_BITS;
  localparam int unsigned Lines    = 2 ** INDEX_BITS;

  // Fetch address split
  logic [LineBits-1:0]      pc_line;
  logic [INDEX_BITS-1:0]    pc_idx;
  logic [TagBits-1:0]       pc_tag;
  logic [WORD_OFF_BITS-1:0] pc_off;
  logic                     unused_addr;

  assign pc_line     = IF_addr[ADDR_WIDTH-1 -: LineBits];
  assign pc_idx      = pc_line[INDEX_BITS-1:0];
  assign pc_tag      = pc_line[LineBits-1 -: TagBits];
  assign pc_off      = IF_addr[2 +: WORD_OFF_BITS];
  assign unused_addr = ^{IF_addr[31:ADDR_WIDTH], IF_addr[1:0]};

  // State
  ic_state_e                state_q, state_d;
  logic [WORD_OFF_BITS-1:0] cnt_q, cnt_d;
  logic [LineBits-1:0]      line_q;
  logic [Lines-1:0]         valid_q;
  logic [TagBits-1:0]       tag_arr [Lines];

  logic [INDEX_BITS-1:0] idx_q;
  logic [TagBits-1:0]    tag_q;
  assign idx_q = line_q[INDEX_BITS-1:0];
  assign tag_q = line_q[LineBits-1 -: TagBits];

  // Lookup and refill qualifiers
  logic hit, lookup, hit_fire, miss_fire;
  logic mc_ack, abort, last_word, fill_we, fill_done;

  assign hit       = valid_q[pc_idx] && (tag_arr[pc_idx] == pc_tag);
  assign lookup    = rdy && (state_q == IcIdle) && IF_addr_sgn && !rollback && !flush;
  assign hit_fire  = lookup && hit;
  assign miss_fire = lookup && !hit;
  assign mc_ack    = rdy && MC_val_sgn;
  assign abort     = rollback || flush;
  assign last_word = (cnt_q == '1);
  assign fill_we   = (state_q == IcRefill) && mc_ack && !abort;
  assign fill_done = fill_we && last_word;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (rdy) begin
      unique case (state_q)
        IcIdle: begin
          if (miss_fire) begin
            state_d = IcRefill;
            cnt_d   = '0;
          end
        end
        IcRefill: begin
          // An aborted refill must still consume the word already requested
          if (abort) begin
            state_d = mc_ack ? IcIdle : IcDrain;
          end else if (mc_ack) begin
            cnt_d = cnt_q + WORD_OFF_BITS'(1);
            if (last_word) begin
              state_d = IcIdle;
            end
          end
        end
        IcDrain: begin
          if (mc_ack) begin
            state_d = IcIdle;
          end
        end
        default: state_d = IcIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IcIdle;
      cnt_q   <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (miss_fire) begin
        line_q <= pc_line;
      end
    end
  end

  // Flush wins over a same-cycle line completion
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (rdy) begin
      if (flush) begin
        valid_q <= '0;
      end else if (miss_fire) begin
        valid_q[pc_idx] <= 1'b0;
      end else if (fill_done) begin
        valid_q[idx_q] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_arr[idx_q] <= tag_q;
    end
  end

  logic [31:0] line_word;

  icache_line_data #(
    .ADDR_BITS(INDEX_BITS + WORD_OFF_BITS)
  ) u_data (
    .clk  (clk),
    .we   (fill_we),
    .waddr({idx_q, cnt_q}),
    .wdata(MC_val),
    .raddr({pc_idx, pc_off}),
    .rdata(line_word)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      IF_val     <= '0;
      IF_val_sgn <= 1'b0;
    end else begin
      IF_val_sgn <= hit_fire;
      if (hit_fire) begin
        IF_val <= line_word;
      end
    end
  end

  assign Mc_addr_sgn = (state_q != IcIdle);
  assign Mc_addr     = 32'({line_q, cnt_q, 2'b00});

endmodule

// File: doc/icache_line.md
Name: icache_line

Overview:
- Parametrised successor to the single-word direct-mapped instruction cache; sits between ifetch and the memory controller.
- Direct-mapped, with multi-word lines of 2^WORD_OFF_BITS instructions.
- On a miss it fills the whole line through a sequential word-by-word burst to the memory controller.
- Supports rollback abort during a refill and a full-cache flush for fence.i.

Parameters:
ADDR_WIDTH, 18, effective byte-address bits used for tag, index and offset; upper PC bits ignored.
INDEX_BITS, 6, line index bits; 64 lines.
WORD_OFF_BITS, 2, word-in-line bits; 4 words (16 B) per line.
TAG_BITS (local), ADDR_WIDTH-2-WORD_OFF_BITS-INDEX_BITS, default 8.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
rdy  in  1  global ready; low freezes the block
rollback  in  1  branch-mispredict flush
flush  in  1  invalidate all lines (fence.i)
IF_addr  in  32  fetch PC; bits [1:0] ignored
IF_addr_sgn  in  1  fetch request valid
IF_val  out  32  instruction
IF_val_sgn  out  1  IF_val valid, one-cycle pulse per delivered instruction
Mc_addr  out  32  refill word address, word aligned
Mc_addr_sgn  out  1  refill request active
MC_val  in  32  returned word
MC_val_sgn  in  1  MC_val valid; completes the current word request

Behaviour:
- Address split:
  - offset = pc[2 +: WORD_OFF_BITS]
  - index = pc[2+WORD_OFF_BITS +: INDEX_BITS]
  - tag = pc[2+WORD_OFF_BITS+INDEX_BITS +: TAG_BITS]
  - hit = valid[index] && tag_arr[index]==tag
- Reset (rst=0, asynchronous):
  - valid all 0, state IDLE, word counter 0.
  - IF_val=0, IF_val_sgn=0.
  - Data and tag arrays are not reset.
- rdy=0:
  - State, counter, arrays and valid are frozen.
  - IF_val_sgn<=0.
  - MC_val_sgn is guaranteed low by the memory controller while rdy=0.
- FSM states: IDLE, REFILL, DRAIN.
- IDLE:
  - IF_addr_sgn && hit: next cycle IF_val=data[index][offset] and IF_val_sgn=1 (1-cycle hit latency). Back-to-back hits give one instruction per cycle.
  - IF_addr_sgn && !hit: latch base={pc[ADDR_WIDTH-1:2+WORD_OFF_BITS], 0s}, tag and index; counter=0; valid[index]<=0; go to REFILL. IF_val_sgn=0.
  - Otherwise IF_val_sgn=0.
- REFILL:
  - Mc_addr_sgn=1 (combinational from state).
  - Mc_addr=base + counter*4, zero-extended to 32.
  - On MC_val_sgn: write MC_val to data[index][counter] and increment counter. Mc_addr advances the following cycle.
  - On the last word: tag_arr[index]<=tag, valid[index]<=1, go to IDLE.
  - The requesting PC is re-looked-up in IDLE and hits one cycle later.
  - Miss penalty = 2^WORD_OFF_BITS × MC latency + 2 cycles.
  - IF_addr may change during REFILL; the refill completes regardless.
- rollback or flush in REFILL:
  - With MC_val_sgn in the same cycle: discard the word, valid[index] stays 0, go to IDLE.
  - Otherwise go to DRAIN.
- DRAIN:
  - Mc_addr_sgn=1 with Mc_addr held, until MC_val_sgn.
  - The returned word is discarded; then go to IDLE.
  - rollback and flush are ignored while in DRAIN.
- rollback in IDLE: IF_val_sgn<=0 and no lookup that cycle.
- flush in any state: all valid<=0 at the clock edge.
  - flush has priority over a same-cycle line completion, so the line is not validated.
  - IF_val_sgn<=0.
- Simultaneous rollback and IF_addr_sgn: rollback wins; no response.
- Counter wraps only via the completion transition; width WORD_OFF_BITS.

Decomposition:
- Add to defines.v:
  - state encodings IC_IDLE/IC_REFILL/IC_DRAIN (2 bits)
  - default ICL_INDEX_BITS, ICL_WORD_OFF_BITS, ICL_ADDR_WIDTH
  - existing TRUE/FALSE reused
- Sub-module icache_line_data: 2^(INDEX_BITS+WORD_OFF_BITS)×32 word array with a synchronous write port and an asynchronous read port.
- Tag and valid arrays stay in icache_line.

Test Plan:
- Cold miss: reset, IF_addr=0x1004 with IF_addr_sgn held, MC returns 0xA0,0xA1,0xA2,0xA3 each 3 cycles after request.
  - Mc_addr sequence is 0x1000,0x1004,0x1008,0x100C.
  - IF_val=0xA1 with IF_val_sgn pulse after the 4th word +2 cycles.
- Line hit: immediately after the cold-miss test, IF_addr=0x100C → IF_val=0xA3 next cycle, with no Mc_addr_sgn.
- Conflict eviction: IF_addr=0x1000 then 0x1400 (same index 0, different tag). Both miss; the second refill overwrites the line; revisiting 0x1000 misses again.
- Rollback mid-refill: rollback during the 2nd word request.
  - Mc_addr_sgn holds 0x1004 until MC_val_sgn, then drops.
  - The line stays invalid and the next fetch of 0x1000 re-misses.
- Flush: after filling the line at 0x1000, pulse flush; next fetch of 0x1000 → Mc_addr_sgn=1, Mc_addr=0x1000.
- rdy/reset: rdy=0 for 5 cycles mid-refill → Mc_addr and counter unchanged, IF_val_sgn=0, then refill resumes. Asserting rst=0 asynchronously mid-refill clears IF_val_sgn and Mc_addr_sgn immediately.
